uart_receiver: RTL



---
 rtl/uart_receiver_if.sv | 31 +++
 rtl/uart_receiver.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Receive-side bundle between the UART receiver and its consumer: the serial
// line in, and the byte holding register with its status flags out.
interface uart_receiver_if;
  logic       rx;
  logic       rx_Ack;
  logic [7:0] rx_Data;
  logic       rx_Valid;
  logic       frame_Err;
  logic       overrun_Err;
  logic       rx_Busy;

  modport slave (
    input  rx,
    input  rx_Ack,
    output rx_Data,
    output rx_Valid,
    output frame_Err,
    output overrun_Err,
    output rx_Busy
  );

  modport master (
    output rx,
    output rx_Ack,
    input  rx_Data,
    input  rx_Valid,
    input  frame_Err,
    input  overrun_Err,
    input  rx_Busy
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver: two-flop synchroniser, start-bit validation,
// three-sample majority vote per bit, and a valid/ack holding register.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           sample_Clk,
  input  logic           reset,
  uart_receiver_if.slave bus
);
  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] T_SAMP_A = TW'(MID - 1);
  localparam logic [TW-1:0] T_SAMP_B = TW'(MID);
  localparam logic [TW-1:0] T_VOTE   = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [2:0]    state_r;
  logic [TW-1:0] tick_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          sync1_r;
  logic          rx_s;
  logic          samp_a_r;
  logic          samp_b_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          frame_r;
  logic          overrun_r;

  logic [TW-1:0] tick_next_s;
  logic          counting_s;
  logic          vote_s;

  // Tick advance, bit-window activity and the mid-bit majority vote.
  always_comb begin
    tick_next_s = '0;
    counting_s  = 1'b0;
    vote_s      = majority3(samp_a_r, samp_b_r, rx_s);
    if (tick_r == T_LAST) begin
      tick_next_s = '0;
    end else begin
      tick_next_s = tick_r + TW'(1);
    end
    if ((state_r == START) || (state_r == DATA) || (state_r == STOP)) begin
      counting_s = 1'b1;
    end else begin
      counting_s = 1'b0;
    end
  end

  // Synchroniser, receive FSM and holding register.
  always_ff @(posedge sample_Clk) begin
    if (reset) begin
      state_r   <= IDLE;
      tick_r    <= '0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      sync1_r   <= 1'b1;
      rx_s      <= 1'b1;
      samp_a_r  <= 1'b1;
      samp_b_r  <= 1'b1;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      frame_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      sync1_r <= bus.rx;
      rx_s    <= sync1_r;

      // Clears first so that a flag set later in this block wins.
      if (bus.rx_Ack) begin
        valid_r   <= 1'b0;
        frame_r   <= 1'b0;
        overrun_r <= 1'b0;
      end

      if (counting_s) begin
        tick_r <= tick_next_s;
        if (tick_r == T_SAMP_A) samp_a_r <= rx_s;
        if (tick_r == T_SAMP_B) samp_b_r <= rx_s;
      end

      case (state_r)
        IDLE: begin
          tick_r <= '0;
          if (!rx_s) state_r <= START;
        end
        START: begin
          if ((tick_r == T_VOTE) && vote_s) begin
            state_r <= IDLE;
            tick_r  <= '0;
          end else if (tick_r == T_LAST) begin
            state_r   <= DATA;
            bit_cnt_r <= 3'd0;
          end
        end
        DATA: begin
          if (tick_r == T_VOTE) shift_r <= {vote_s, shift_r[7:1]};
          if (tick_r == T_LAST) begin
            if (bit_cnt_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        STOP: begin
          // Leave half a bit early so the next start edge is never missed.
          if (tick_r == T_VOTE) begin
            tick_r <= '0;
            if (vote_s) begin
              data_r  <= shift_r;
              valid_r <= 1'b1;
              if (valid_r && !bus.rx_Ack) overrun_r <= 1'b1;
              state_r <= IDLE;
            end else begin
              frame_r <= 1'b1;
              state_r <= BREAK;
            end
          end
        end
        BREAK: begin
          tick_r <= '0;
          if (rx_s) state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          tick_r  <= '0;
        end
      endcase
    end
  end

  assign bus.rx_Data     = data_r;
  assign bus.rx_Valid    = valid_r;
  assign bus.frame_Err   = frame_r;
  assign bus.overrun_Err = overrun_r;
  assign bus.rx_Busy     = (state_r != IDLE);
endmodule
